// File: rtl/fix2float_arbiter.sv
// Round-robin arbiter that shares one 32.32 fixed-point to float converter between requesters.
// Latency: 2 cycles from the request handshake to result_valid_o. Sustains one conversion per cycle.
// Backpressure: result_ready_i low stalls stage 2, then stage 1, then holds req_ready_o at zero.
package config_pkg;

    localparam int unsigned FIX64_LEN = 64;

    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64};

endpackage

module fix2float_arbiter #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg       = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NR_REQ        = 2,
    parameter int unsigned           TRANS_ID_BITS = 3
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic                                             flush_i,
    input  logic [NR_REQ-1:0]                                req_valid_i,
    output logic [NR_REQ-1:0]                                req_ready_o,
    input  logic [NR_REQ-1:0][config_pkg::FIX64_LEN-1:0]     req_fix_i,
    input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]             req_id_i,
    output logic [config_pkg::FIX64_LEN-1:0]                 conv_fix_o,
    input  logic [CVA6Cfg.XLEN-1:0]                          conv_float_i,
    output logic                                             result_valid_o,
    input  logic                                             result_ready_i,
    output logic [CVA6Cfg.XLEN-1:0]                          result_o,
    output logic [TRANS_ID_BITS-1:0]                         result_id_o,
    output logic [$clog2(NR_REQ)-1:0]                        result_src_o,
    output logic                                             busy_o
);

    localparam int unsigned XLEN  = CVA6Cfg.XLEN;
    localparam int unsigned SRC_W = $clog2(NR_REQ);
    localparam int unsigned FIX_W = config_pkg::FIX64_LEN;

    logic [SRC_W-1:0]         rr_q;

    logic                     s1_valid;
    logic [FIX_W-1:0]         s1_fix;
    logic [TRANS_ID_BITS-1:0] s1_id;
    logic [SRC_W-1:0]         s1_src;

    logic                     s2_valid;
    logic [XLEN-1:0]          s2_res;
    logic [TRANS_ID_BITS-1:0] s2_id;
    logic [SRC_W-1:0]         s2_src;

    logic                     s2_adv;
    logic                     s1_adv;
    logic                     accept_ok;
    logic                     grant_vld;
    logic [SRC_W-1:0]         grant_idx;
    logic                     hs;

    assign s2_adv    = !s2_valid || result_ready_i;
    assign s1_adv    = !s1_valid || s2_adv;
    assign accept_ok = s1_adv && !flush_i;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        logic [SRC_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NR_REQ; k++) begin
            cand = SRC_W'((32'(rr_q) + k) % NR_REQ);
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign hs = grant_vld && accept_ok;

    always_comb begin
        req_ready_o = '0;
        if (hs) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= SRC_W'(NR_REQ - 1);
            s1_valid <= 1'b0;
            s1_fix   <= '0;
            s1_id    <= '0;
            s1_src   <= '0;
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_id    <= '0;
            s2_src   <= '0;
        end else begin
            if (hs) begin
                s1_fix <= req_fix_i[grant_idx];
                s1_id  <= req_id_i[grant_idx];
                s1_src <= grant_idx;
                rr_q   <= grant_idx;
            end
            // The upper word is the NaN box on 64-bit cores and truncates away on 32-bit ones.
            if (s1_adv && s1_valid) begin
                s2_res <= XLEN'({32'hFFFF_FFFF, conv_float_i[31:0]});
                s2_id  <= s1_id;
                s2_src <= s1_src;
            end
            if (flush_i) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s1_adv) begin
                    s1_valid <= hs;
                end
                if (s2_adv) begin
                    s2_valid <= s1_valid;
                end
            end
        end
    end

    assign conv_fix_o     = s1_fix;
    assign result_valid_o = s2_valid;
    assign result_o       = s2_res;
    assign result_id_o    = s2_id;
    assign result_src_o   = s2_src;
    assign busy_o         = s1_valid || s2_valid;

    generate
        if (XLEN > 32) begin : g_conv_hi
            logic unused_conv_hi;
            assign unused_conv_hi = ^conv_float_i[XLEN-1:32];
        end
    endgenerate

endmodule

// File: doc/fix2float_arbiter.md
# fix2float_arbiter

Shares one fix642float conversion datapath (32.32 signed fixed point to single-precision float) between `NR_REQ` requesters, typically the CORDIC sin/cos/atan result ports. Round-robin arbitration selects one request per cycle into a two-stage pipeline: an operand register drives the external converter, and a result register presents the float with its requester index and transaction ID. Valid/ready handshakes on both sides allow full throughput of one conversion per cycle.

## Interface
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration; supplies XLEN.
- `NR_REQ`, default 2: number of requesters, at least 2.
- `TRANS_ID_BITS`, default 3: width of the transaction ID carried with each request.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous kill of all in-flight conversions.
- `req_valid_i`  in  NR_REQ  per-requester request valid.
- `req_ready_o`  out  NR_REQ  per-requester accept; one-hot or zero.
- `req_fix_i`  in  NR_REQ x FIX64_LEN  fixed-point operand per requester.
- `req_id_i`  in  NR_REQ x TRANS_ID_BITS  transaction ID per requester.
- `conv_fix_o`  out  FIX64_LEN  operand to the converter; equals the stage-1 register.
- `conv_float_i`  in  XLEN  converter result; combinational from `conv_fix_o`, bits 31:0 used.
- `result_valid_o`  out  1  stage-2 result valid.
- `result_ready_i`  in  1  consumer accept.
- `result_o`  out  XLEN  float result.
- `result_id_o`  out  TRANS_ID_BITS  ID of the result.
- `result_src_o`  out  $clog2(NR_REQ)  index of the requester that produced the result.
- `busy_o`  out  1  high when either stage holds valid data.

## Operation
- Stage 1 holds `s1_valid`, operand, ID and source. Stage 2 holds `s2_valid`, float, ID and source.
- Advance rules:
  - `s2_adv = !s2_valid | result_ready_i`.
  - `s1_adv = !s1_valid | s2_adv`.
  - New requests are accepted only when `s1_adv & !flush_i`.
- Arbitration is round-robin:
  - `rr_q` holds the index of the last granted requester.
  - Priority starts at `rr_q+1` and wraps modulo NR_REQ.
  - The grant goes to the first requester with `req_valid_i` set.
  - `req_ready_o[g]` = grant & accept-possible.
  - `rr_q` updates to `g` only on a completed handshake.
- `req_ready_o` depends combinationally on `req_valid_i`. Requesters must not make valid depend on ready.
- On handshake, stage 1 loads `req_fix_i[g]`, `req_id_i[g]` and `g`, and sets `s1_valid`. Without a handshake but with `s1_adv`, `s1_valid` clears.
- On `s1_adv & s1_valid`, stage 2 loads `conv_float_i[31:0]` plus stage-1 ID and source, and sets `s2_valid`. When `s2_adv` holds and stage 1 is empty, `s2_valid` clears.
- `result_o` formatting:
  - XLEN = 64: `{32'hFFFF_FFFF, float}` (NaN-boxed).
  - XLEN = 32: float directly.
- Stalls: while `result_valid_o & !result_ready_i`, all stage-2 outputs are held stable. Stage 1 also holds if valid.
- `flush_i` has priority over everything:
  - clears `s1_valid` and `s2_valid` at the next edge;
  - forces every `req_ready_o` to 0 in that cycle;
  - leaves `rr_q` unchanged.
- Data registers are not cleared by flush, only their valid bits.

## Timing
- Reset values:
  - `s1_valid = s2_valid = 0`, so `result_valid_o = 0`, `busy_o = 0`, `req_ready_o = 0`.
  - `conv_fix_o = 0`; `result_o`, `result_id_o`, `result_src_o` = 0.
  - `rr_q = NR_REQ-1`, so requester 0 has first priority.
- Latency: a request accepted at edge N produces `result_valid_o` high in the cycle after edge N+1, i.e. 2 cycles.
- Throughput: one accept per cycle while `result_ready_i` is high.
- Full pipeline (both stages valid, `result_ready_i` low): `req_ready_o` is all zero.
- Simultaneous pop and push: with stage 2 consumed and stage 1 advancing in the same cycle, a new request is still accepted with no bubble.
- Reset mid-operation: all valids drop immediately (asynchronous). No result is emitted for in-flight requests.
- Flush while the consumer stalls: stage 2 is dropped at the next edge without `result_ready_i`.

## Test plan
- Single request: requester 0 sends fix `0x0000_0001_0000_0000`, ID 5 -> two cycles later `result_valid_o=1`, `result_o=0xFFFF_FFFF_3F80_0000` (XLEN=64), `result_id_o=5`, `result_src_o=0`.
- Sign and fraction: back-to-back fix `0xFFFF_FFFF_0000_0000`, then `0x0000_0000_8000_0000`, then `0` -> floats `0xBF80_0000`, `0x3F00_0000`, `0x0000_0000` on three consecutive cycles.
- Round-robin: both requesters hold valid for 4 cycles from reset -> grants alternate 0,1,0,1 and `result_src_o` follows the same order.
- Backpressure: `result_ready_i` low for 5 cycles with requester 1 streaming -> exactly 2 requests accepted, then `req_ready_o=0`. Outputs stay stable; releasing ready drains in order with no loss or duplication.
- Flush: issue a request, assert `flush_i` one cycle later -> no `result_valid_o`, `busy_o=0` after the edge. The next request is granted starting from requester `rr_q+1`.
- Async reset asserted mid-stream with both stages full -> `result_valid_o` and `busy_o` fall without a clock edge; after release, requester 0 is granted first.
